// File: rtl/diff_eq_inverse_pkg.sv
// Shared definitions for the difference-equation inverse decoder:
// FSM encodings, width helpers and the history shift amount.
package diff_eq_inverse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SAT  = 2'd2
  } state_t;

  // y[n-1] enters the recurrence halved by an arithmetic (floor) shift
  localparam int SHIFT_AMT = 1;

  function automatic int y_w(input int n_bits);
    return n_bits + 3;
  endfunction

  function automatic int acc_w(input int n_bits);
    return n_bits + 5;
  endfunction

endpackage

// File: rtl/diff_eq_inverse_sat_clip.sv
// Combinational clip of the signed accumulator into the unsigned sample range,
// flagging any value that had to be clipped.
module diff_eq_inverse_sat_clip
  import diff_eq_inverse_pkg::*;
#(
  parameter int N_BITS = 8
) (
  input  logic signed [N_BITS+4:0] s,
  output logic        [N_BITS-1:0] x,
  output logic                     oor
);

  localparam int ACC_W = acc_w(N_BITS);
  localparam logic signed [ACC_W-1:0] X_MAX = ACC_W'((1 << N_BITS) - 1);

  always_comb begin
    x   = s[N_BITS-1:0];
    oor = 1'b0;
    if (s[ACC_W-1]) begin
      x   = '0;
      oor = 1'b1;
    end else if (s > X_MAX) begin
      x   = '1;
      oor = 1'b1;
    end
  end

endmodule

// File: rtl/diff_eq_inverse.sv
// Inverse of y[n] = x[n] - x[n-1] + x[n-2] + (y[n-1] >>> 1): rebuilds x[n]
// from the filtered stream with one cycle of latency.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   ST_IDLE | no sample since reset/clear; history is all zero
//   ST_RUN  | decoding, every reconstruction so far in range
//   ST_SAT  | a reconstruction was clipped; o_err latched until clear
module diff_eq_inverse
  import diff_eq_inverse_pkg::*;
#(
  parameter int N_BITS = 8
) (
  input  logic                     clock,
  input  logic                     i_reset,
  input  logic signed [N_BITS+2:0] i_y,
  input  logic                     i_valid,
  input  logic                     i_clear,
  output logic        [N_BITS-1:0] o_x,
  output logic                     o_valid,
  output logic                     o_err
);

  localparam int Y_W   = y_w(N_BITS);
  localparam int ACC_W = acc_w(N_BITS);

  state_t                  state;
  logic signed [Y_W-1:0]   y1;
  logic        [N_BITS-1:0] x1;
  logic        [N_BITS-1:0] x2;
  logic signed [ACC_W-1:0] s;
  logic        [N_BITS-1:0] x_hat;
  logic                    oor;

  // Accumulator is wide enough that no combination of inputs can wrap
  assign s = ACC_W'(i_y)
           - ACC_W'(y1 >>> SHIFT_AMT)
           + $signed({{(ACC_W-N_BITS){1'b0}}, x1})
           - $signed({{(ACC_W-N_BITS){1'b0}}, x2});

  diff_eq_inverse_sat_clip #(.N_BITS(N_BITS)) u_sat_clip (
    .s   (s),
    .x   (x_hat),
    .oor (oor)
  );

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state   <= ST_IDLE;
      y1      <= '0;
      x1      <= '0;
      x2      <= '0;
      o_x     <= '0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
    end else if (i_clear) begin
      state   <= ST_IDLE;
      y1      <= '0;
      x1      <= '0;
      x2      <= '0;
      o_x     <= '0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
    end else if (i_valid) begin
      o_x     <= x_hat;
      o_valid <= 1'b1;
      // History carries the clipped value so decoding stays bounded after an error
      x2      <= x1;
      x1      <= x_hat;
      y1      <= i_y;
      if (oor) begin
        o_err <= 1'b1;
        state <= ST_SAT;
      end else if (state == ST_IDLE) begin
        state <= ST_RUN;
      end
    end else begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_diff_eq_inverse.sv
// Self-checking bench for diff_eq_inverse: vector table, hand sequences and a
// loopback through a behavioural forward filter, all scored through a queue.
module tb_diff_eq_inverse;

  localparam int N_BITS = 8;

  logic               clock = 1'b0;
  logic               i_reset;
  logic signed [10:0] i_y;
  logic               i_valid;
  logic               i_clear;
  logic [7:0]         o_x;
  logic               o_valid;
  logic               o_err;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] sb_q[$];
  logic [7:0] last_x = 8'd0;

  typedef struct {
    logic signed [10:0] y;
    logic               v;
    logic               c;
    logic [7:0]         ex;
    logic               ee;
  } vec_t;

  vec_t tbl[15];

  always #5 clock = ~clock;

  diff_eq_inverse #(.N_BITS(N_BITS)) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .i_y     (i_y),
    .i_valid (i_valid),
    .i_clear (i_clear),
    .o_x     (o_x),
    .o_valid (o_valid),
    .o_err   (o_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1ns after the rising edge
  task automatic step(input logic signed [10:0] y, input logic v, input logic c,
                      input logic [7:0] ex, input logic ee, input string tag);
    @(negedge clock);
    i_y     = y;
    i_valid = v;
    i_clear = c;
    if (v && !c) sb_q.push_back(ex);
    @(posedge clock);
    #1;
    check({tag, "/valid"}, 32'(o_valid), 32'(v && !c));
    if (c) last_x = 8'd0;
    if (o_valid) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s/scoreboard: got output %0d want none", tag, o_x);
      end else begin
        last_x = sb_q.pop_front();
      end
    end
    check({tag, "/x"}, 32'(o_x), 32'(last_x));
    check({tag, "/err"}, 32'(o_err), 32'(ee));
  endtask

  initial begin
    int fx1, fx2, fy1, fy, xv;
    int xs[4];

    i_reset = 1'b0;
    i_y     = '0;
    i_valid = 1'b0;
    i_clear = 1'b0;
    #12;
    check("por/x", 32'(o_x), 32'd0);
    check("por/valid", 32'(o_valid), 32'd0);
    check("por/err", 32'(o_err), 32'd0);
    @(negedge clock);
    i_reset = 1'b1;

    // Async reset mid-stream, with outputs non-zero just before it
    step(11'sd1023, 1'b1, 1'b0, 8'd255, 1'b1, "rst_pre");
    #2;
    i_reset = 1'b0;
    #1;
    check("rst/x", 32'(o_x), 32'd0);
    check("rst/valid", 32'(o_valid), 32'd0);
    check("rst/err", 32'(o_err), 32'd0);
    sb_q.delete();
    last_x = 8'd0;
    @(negedge clock);
    i_valid = 1'b0;
    i_reset = 1'b1;
    step(11'sd4, 1'b1, 1'b0, 8'd4, 1'b0, "rst_n0");
    step(11'sd2, 1'b1, 1'b0, 8'd4, 1'b0, "rst_n1");

    // Step response of x=4, then range boundaries from zero history
    tbl[0]  = '{11'sd0,    1'b0, 1'b1, 8'd0,   1'b0};
    tbl[1]  = '{11'sd4,    1'b1, 1'b0, 8'd4,   1'b0};
    tbl[2]  = '{11'sd2,    1'b1, 1'b0, 8'd4,   1'b0};
    tbl[3]  = '{11'sd5,    1'b1, 1'b0, 8'd4,   1'b0};
    tbl[4]  = '{11'sd6,    1'b1, 1'b0, 8'd4,   1'b0};
    tbl[5]  = '{11'sd7,    1'b1, 1'b0, 8'd4,   1'b0};
    tbl[6]  = '{11'sd7,    1'b1, 1'b0, 8'd4,   1'b0};
    tbl[7]  = '{11'sd7,    1'b1, 1'b0, 8'd4,   1'b0};
    tbl[8]  = '{11'sd0,    1'b0, 1'b1, 8'd0,   1'b0};
    tbl[9]  = '{11'sd255,  1'b1, 1'b0, 8'd255, 1'b0};
    tbl[10] = '{11'sd0,    1'b0, 1'b1, 8'd0,   1'b0};
    tbl[11] = '{11'sd256,  1'b1, 1'b0, 8'd255, 1'b1};
    tbl[12] = '{11'sd0,    1'b0, 1'b1, 8'd0,   1'b0};
    tbl[13] = '{-11'sd5,   1'b1, 1'b0, 8'd0,   1'b1};
    tbl[14] = '{11'sd0,    1'b0, 1'b1, 8'd0,   1'b0};
    for (int i = 0; i < 15; i++)
      step(tbl[i].y, tbl[i].v, tbl[i].c, tbl[i].ex, tbl[i].ee, $sformatf("tbl%0d", i));

    // Gaps: idle cycles carry junk on i_y that must not touch history
    step(11'sd4,    1'b1, 1'b0, 8'd4, 1'b0, "gap0");
    step(11'sd999,  1'b0, 1'b0, 8'd0, 1'b0, "gap1");
    step(11'sd2,    1'b1, 1'b0, 8'd4, 1'b0, "gap2");
    step(-11'sd300, 1'b0, 1'b0, 8'd0, 1'b0, "gap3");
    step(11'sd5,    1'b1, 1'b0, 8'd4, 1'b0, "gap4");
    step(11'sd0,    1'b0, 1'b0, 8'd0, 1'b0, "gap5");
    step(11'sd6,    1'b1, 1'b0, 8'd4, 1'b0, "gap6");
    step(11'sd7,    1'b1, 1'b0, 8'd4, 1'b0, "gap7");

    // Overflow from IDLE; sticky error survives later samples until clear
    step(11'sd0,    1'b0, 1'b1, 8'd0,   1'b0, "ovf_clr");
    step(11'sd1023, 1'b1, 1'b0, 8'd255, 1'b1, "ovf0");
    step(11'sd0,    1'b1, 1'b0, 8'd0,   1'b1, "ovf1");
    step(11'sd0,    1'b0, 1'b0, 8'd0,   1'b1, "ovf2");
    step(11'sd4,    1'b1, 1'b0, 8'd0,   1'b1, "ovf3");
    step(11'sd0,    1'b0, 1'b1, 8'd0,   1'b0, "ovf_end");

    // Clear beats valid in the same cycle; next sample sees zero history
    step(11'sd1023, 1'b1, 1'b0, 8'd255, 1'b1, "cv0");
    step(11'sd100,  1'b1, 1'b1, 8'd0,   1'b0, "cv1");
    step(11'sd7,    1'b1, 1'b0, 8'd7,   1'b0, "cv2");
    step(11'sd7,    1'b1, 1'b0, 8'd11,  1'b0, "cv3");

    // Loopback through a behavioural forward filter
    step(11'sd0, 1'b0, 1'b1, 8'd0, 1'b0, "lb_clr");
    xs = '{4, 16, 0, 255};
    fx1 = 0;
    fx2 = 0;
    fy1 = 0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 50; j++) begin
        xv  = xs[k];
        fy  = xv - fx1 + fx2 + (fy1 >>> 1);
        fx2 = fx1;
        fx1 = xv;
        fy1 = fy;
        step(11'(fy), 1'b1, 1'b0, 8'(xv), 1'b0, $sformatf("lb%0d_%0d", k, j));
      end
    end

    step(11'sd0, 1'b0, 1'b0, 8'd0, 1'b0, "drain");
    check("scoreboard_left", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
